// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and decode helper for alu_iter.
// Defining ALU_DIV_EN makes the divide opcode multi-cycle.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADD2 = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] opcode);
`ifdef ALU_DIV_EN
    return (opcode == OP_MUL) || (opcode == OP_DIV);
`else
    return opcode == OP_MUL;
`endif
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// EX-stage request/result bundle between pipeline control (master) and the ALU (slave).
interface alu_iter_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUout;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             negative;
  logic             OverflowDetected;
  logic             illegal;

  modport master (
    output start, opcode, A, B,
    input  busy, done, ALUout, hi, zero, negative, OverflowDetected, illegal
  );

  modport slave (
    input  start, opcode, A, B,
    output busy, done, ALUout, hi, zero, negative, OverflowDetected, illegal
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Shift-add multiplier / restoring divider (divider only with ALU_DIV_EN), one step per step pulse.
// Latency: WIDTH steps after load; loNext/hiNext show the register contents after the current step.
// Backpressure: none; the owner sequences load and step.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
`ifdef ALU_DIV_EN
  input  logic             divMode,
`endif
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] loNext,
  output logic [WIDTH-1:0] hiNext
);

  // loReg: multiplier / product low, or dividend / quotient; hiReg: product high or remainder
  logic [WIDTH-1:0] loReg;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   mulSum;
`ifdef ALU_DIV_EN
  logic             divReg;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divDiff;
`endif

  always_comb begin
    mulSum = {1'b0, hiReg} + {1'b0, opnd};
    if (loReg[0]) begin
      hiNext = mulSum[WIDTH:1];
      loNext = {mulSum[0], loReg[WIDTH-1:1]};
    end else begin
      hiNext = {1'b0, hiReg[WIDTH-1:1]};
      loNext = {hiReg[0], loReg[WIDTH-1:1]};
    end
`ifdef ALU_DIV_EN
    // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    divShift = {hiReg, loReg[WIDTH-1]};
    divDiff  = divShift - {1'b0, opnd};
    if (divReg) begin
      if (!divDiff[WIDTH]) begin
        hiNext = divDiff[WIDTH-1:0];
        loNext = {loReg[WIDTH-2:0], 1'b1};
      end else begin
        hiNext = divShift[WIDTH-1:0];
        loNext = {loReg[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      loReg  <= '0;
      hiReg  <= '0;
      opnd   <= '0;
`ifdef ALU_DIV_EN
      divReg <= 1'b0;
`endif
    end else if (load) begin
      hiReg  <= '0;
`ifdef ALU_DIV_EN
      divReg <= divMode;
      loReg  <= divMode ? opA : opB;
      opnd   <= divMode ? opB : opA;
`else
      loReg  <= opB;
      opnd   <= opA;
`endif
    end else if (step) begin
      loReg <= loNext;
      hiReg <= hiNext;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// WIDTH-bit EX-stage ALU with iterative mul, and iterative div when ALU_DIV_EN is defined.
// Latency: done 1 cycle after start for single-cycle ops, WIDTH+1 cycles for mul/div.
// Backpressure: start is ignored while busy; results and flags hold until the next done.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic       clock,
  input logic       reset,
  alu_iter_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH + 1);
  localparam logic [SHAMT_W:0] WIDTH_S = (SHAMT_W + 1)'(WIDTH);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] count;
  logic             loadSingle;
  logic             startIter;
  logic             finishIter;
  logic             stepEn;
  logic             divByZero;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sraRes;
  logic [SHAMT_W-1:0] shamt;
  logic             bigShift;
  logic [WIDTH-1:0] scLo;
  logic [WIDTH-1:0] scHi;
  logic             scOvf;
  logic             scIll;
  logic [WIDTH-1:0] mdLoNext;
  logic [WIDTH-1:0] mdHiNext;

  logic [WIDTH-1:0] aluOutR;
  logic [WIDTH-1:0] hiR;
  logic             doneR;
  logic             zeroR;
  logic             negR;
  logic             ovfR;
  logic             illR;

`ifdef ALU_DIV_EN
  logic             divMode;
  logic             iterDiv;
  assign divMode   = (bus.opcode == OP_DIV);
  assign divByZero = divMode && (bus.B == '0);
`else
  assign divByZero = 1'b0;
`endif

  assign sum    = bus.A + bus.B;
  assign diff   = bus.A - bus.B;
  assign shamt  = bus.B[SHAMT_W-1:0];
  assign sraRes = $signed(bus.A) >>> shamt;
  // The shift amount is the whole of B, not just its low bits.
  assign bigShift = (|bus.B[WIDTH-1:SHAMT_W+1]) || (bus.B[SHAMT_W:0] >= WIDTH_S);

  always_comb begin
    scLo  = '0;
    scHi  = '0;
    scOvf = 1'b0;
    scIll = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_ADD2: begin
        scLo  = sum;
        scOvf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        scLo  = diff;
        scOvf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND: scLo = bus.A & bus.B;
      OP_OR:  scLo = bus.A | bus.B;
      OP_NOT: scLo = ~bus.A;
      OP_SLL: scLo = bigShift ? '0 : (bus.A << shamt);
      OP_SRL: scLo = bigShift ? '0 : (bus.A >> shamt);
      OP_SRA: scLo = bigShift ? {WIDTH{bus.A[WIDTH-1]}} : sraRes;
      OP_SLT: scLo = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_MUL: scLo = '0;
`ifdef ALU_DIV_EN
      OP_DIV: begin
        scLo  = '1;
        scHi  = bus.A;
        scOvf = 1'b1;
      end
`endif
      default: scIll = 1'b1;
    endcase
  end

  always_comb begin
    stateNext  = state;
    loadSingle = 1'b0;
    startIter  = 1'b0;
    finishIter = 1'b0;
    stepEn     = 1'b0;
    case (state)
      // FIN accepts a new request exactly like IDLE, giving back-to-back issue on done.
      ST_IDLE, ST_FIN: begin
        stateNext = ST_IDLE;
        if (bus.start) begin
          if (is_multicycle(bus.opcode) && !divByZero) begin
            startIter = 1'b1;
            stateNext = ST_ITER;
          end else begin
            loadSingle = 1'b1;
          end
        end
      end
      ST_ITER: begin
        stepEn = 1'b1;
        if (count == CNT_W'(1)) begin
          finishIter = 1'b1;
          stateNext  = ST_FIN;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
`ifdef ALU_DIV_EN
      iterDiv <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      if (startIter) begin
        count   <= CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
        iterDiv <= divMode;
`endif
      end else if (stepEn) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clock   (clock),
    .reset   (reset),
    .load    (startIter),
    .step    (stepEn),
`ifdef ALU_DIV_EN
    .divMode (divMode),
`endif
    .opA     (bus.A),
    .opB     (bus.B),
    .loNext  (mdLoNext),
    .hiNext  (mdHiNext)
  );

  // The last step and the result capture share one edge, so capture the stepped values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      doneR   <= 1'b0;
      aluOutR <= '0;
      hiR     <= '0;
      zeroR   <= 1'b0;
      negR    <= 1'b0;
      ovfR    <= 1'b0;
      illR    <= 1'b0;
    end else begin
      doneR <= loadSingle || finishIter;
      if (loadSingle) begin
        aluOutR <= scLo;
        hiR     <= scHi;
        zeroR   <= !scIll && (scLo == '0);
        negR    <= scLo[WIDTH-1];
        ovfR    <= scOvf;
        illR    <= scIll;
      end else if (finishIter) begin
        aluOutR <= mdLoNext;
        hiR     <= mdHiNext;
        zeroR   <= (mdLoNext == '0);
        negR    <= mdLoNext[WIDTH-1];
`ifdef ALU_DIV_EN
        ovfR    <= !iterDiv && (mdHiNext != '0);
`else
        ovfR    <= (mdHiNext != '0);
`endif
        illR    <= 1'b0;
      end
    end
  end

  assign bus.busy             = (state == ST_ITER);
  assign bus.done             = doneR;
  assign bus.ALUout           = aluOutR;
  assign bus.hi               = hiR;
  assign bus.zero             = zeroR;
  assign bus.negative         = negR;
  assign bus.OverflowDetected = ovfR;
  assign bus.illegal          = illR;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: arithmetic reference model, queue of expected results, done monitor.
module tb_alu_iter;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         ill;
    bit           multi;
    int           doneEdge;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  alu_iter_if #(.WIDTH(W)) bus();

  alu_iter #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   edgeCount = 0;
  always @(posedge clock) edgeCount++;

  exp_t expQ[$];
  exp_t lastExp;
  int   nChecks = 0;
  int   nPass = 0;
  int   freeEdge = 0;
  int   busyLo = 1;
  int   busyHi = 0;
  int   lastIssue = 0;
  bit   monOn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edgeCount);
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    int     sa, sb, r;
    longint p;
    e  = '{default: 0};
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      4'd0, 4'd2: begin r = sa + sb; e.lo = r[W-1:0]; e.ovf = (r > 32767) || (r < -32768); end
      4'd1: begin r = sa - sb; e.lo = r[W-1:0]; e.ovf = (r > 32767) || (r < -32768); end
      4'd3: e.lo = a & b;
      4'd4: e.lo = a | b;
      4'd5: e.lo = ~a;
      4'd6: e.lo = (b >= 16) ? '0 : (a << b);
      4'd7: e.lo = (b >= 16) ? '0 : (a >> b);
      4'd8: begin r = (b >= 16) ? ((sa < 0) ? -1 : 0) : (sa >>> b); e.lo = r[W-1:0]; end
      4'd9: e.lo = (sa < sb) ? 16'd1 : 16'd0;
      4'd10: begin
        p = longint'(a) * longint'(b);
        e.lo = p[W-1:0]; e.hi = p[2*W-1:W]; e.ovf = (p > 65535); e.multi = 1'b1;
      end
      4'd11: begin
`ifdef ALU_DIV_EN
        if (b == 0) begin e.lo = 16'hFFFF; e.hi = a; e.ovf = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; e.multi = 1'b1; end
`else
        e.ill = 1'b1;
`endif
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = !e.ill && (e.lo == 0);
    e.neg  = e.lo[W-1];
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clock);
    while (edgeCount + 1 < freeEdge) @(negedge clock);
    e = model(op, a, b);
    lastIssue  = edgeCount + 1;
    e.doneEdge = lastIssue + (e.multi ? W : 0);
    expQ.push_back(e);
    if (e.multi) begin busyLo = lastIssue; busyHi = lastIssue + W - 1; end
    freeEdge = lastIssue + (e.multi ? W + 1 : 1);
    bus.start = 1'b1; bus.opcode = op; bus.A = a; bus.B = b;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // A request presented while busy; nothing is queued because it must be dropped.
  task automatic poke(input int atEdge, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    do @(negedge clock); while (edgeCount + 1 < atEdge);
    bus.start = 1'b1; bus.opcode = op; bus.A = a; bus.B = b;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_ALUout"}, bus.ALUout, 0);
    check({tag, "_hi"}, bus.hi, 0);
    check({tag, "_zero"}, bus.zero, 0);
    check({tag, "_negative"}, bus.negative, 0);
    check({tag, "_overflow"}, bus.OverflowDetected, 0);
    check({tag, "_illegal"}, bus.illegal, 0);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (monOn && !reset) begin
      check("busy", bus.busy, (edgeCount >= busyLo) && (edgeCount <= busyHi));
      if (bus.done) begin
        if (expQ.size() == 0) begin
          check("unexpected_done", bus.done, 0);
        end else begin
          e = expQ.pop_front();
          check("done_edge", edgeCount, e.doneEdge);
          check("ALUout", bus.ALUout, e.lo);
          check("hi", bus.hi, e.hi);
          check("zero", bus.zero, e.zero);
          check("negative", bus.negative, e.neg);
          check("overflow", bus.OverflowDetected, e.ovf);
          check("illegal", bus.illegal, e.ill);
          lastExp = e;
        end
      end else begin
        check("hold", {bus.ALUout, bus.hi, bus.zero, bus.negative, bus.OverflowDetected, bus.illegal},
              {lastExp.lo, lastExp.hi, lastExp.zero, lastExp.neg, lastExp.ovf, lastExp.ill});
      end
    end
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int           waitN;
    lastExp    = '{default: 0};
    bus.start  = 1'b0;
    bus.opcode = 4'd0;
    bus.A      = '0;
    bus.B      = '0;
    repeat (2) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b0;
    monOn = 1'b1;

    issue(4'd0, 16'h7FFF, 16'h0001);
    issue(4'd1, 16'h0005, 16'h0005);
    issue(4'd10, 16'h1234, 16'h0100);
    poke(lastIssue + 5, 4'd0, 16'h0001, 16'h0001);
    issue(4'd11, 16'h0064, 16'h0007);
    issue(4'd11, 16'h00AB, 16'h0000);
    issue(4'd8, 16'h8000, 16'd4);
    issue(4'd7, 16'h8000, 16'd16);
    issue(4'd6, 16'h0001, 16'd15);
    issue(4'd8, 16'h8001, 16'h0100);
    issue(4'd9, 16'hFFFF, 16'h0001);

    // Abort a multiply with reset partway through; its result must never appear.
    issue(4'd10, 16'hBEEF, 16'h1357);
    do @(negedge clock); while (edgeCount < lastIssue + 4);
    #1 reset = 1'b1;
    #1 checkAllZero("abort");
    void'(expQ.pop_back());
    busyLo   = 1;
    busyHi   = 0;
    lastExp  = '{default: 0};
    freeEdge = 0;
    #1 reset = 1'b0;

    issue(4'd0, 16'd2, 16'd3);
    issue(4'd15, 16'h1234, 16'h5678);
    issue(4'd12, 16'h0000, 16'h0000);
    issue(4'd4, 16'h00F0, 16'h0F00);

    for (int i = 0; i < 160; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ((op >= 4'd6) && (op <= 4'd8) && ($urandom_range(0, 1) == 0)) b = 16'($urandom_range(0, 20));
      if ((op == 4'd11) && ($urandom_range(0, 3) == 0)) b = '0;
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
      issue(op, a, b);
    end

    waitN = 0;
    while ((expQ.size() != 0) && (waitN < 200)) begin
      @(negedge clock);
      waitN++;
    end
    check("drain_empty", expQ.size(), 0);
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
